// File: rtl/posit_pkg.sv
// posit_pkg: shared field widths and FSM state codes for the posit8 encoder.
// Build option: POSIT_ENC_RNE_EN selects round-to-nearest-even; otherwise truncate.
package posit_pkg;

  // Posit8 field layout {sign, regime, exp, frac}.
  localparam int P_REG_W  = 2;
  localparam int P_EXP_W  = 1;
  localparam int P_FRAC_W = 4;

  // Largest pre-round scale for a 5-bit integer part.
  localparam int K_MAX = 4;

  // The scale k packs directly into {regime, exp}.
  // A rounding carry can push k one past K_MAX.
  localparam int K_W = P_REG_W + P_EXP_W;

  // Encoder FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/posit_rne_round.sv
// posit_rne_round: combinational rounding of a normalised fraction.
// Build option: POSIT_ENC_RNE_EN enables round-to-nearest-even.
// Without it the fraction is truncated and no carry into k can occur.
// Both builds report inexact whenever guard or sticky bits are set.
module posit_rne_round #(
  parameter int P_FRAC_W = 4,
  parameter int K_W      = 3
) (
  input  logic [P_FRAC_W-1:0] frac_in,
  input  logic                guard_in,
  input  logic                sticky_in,
  input  logic [K_W-1:0]      k_in,
  output logic [P_FRAC_W-1:0] frac_out,
  output logic [K_W-1:0]      k_out,
  output logic                inexact
);

  assign inexact = guard_in | sticky_in;

`ifdef POSIT_ENC_RNE_EN
  logic                round_up;
  logic [P_FRAC_W:0]   frac_sum;

  // Round half to even.
  // A carry out of the fraction wraps it to zero and bumps the scale.
  always_comb begin
    round_up = guard_in & (sticky_in | frac_in[0]);
    frac_sum = {1'b0, frac_in} + {{P_FRAC_W{1'b0}}, round_up};
    frac_out = frac_sum[P_FRAC_W-1:0];
    k_out    = frac_sum[P_FRAC_W] ? (k_in + K_W'(1)) : k_in;
  end
`else
  assign frac_out = frac_in;
  assign k_out    = k_in;
`endif

endmodule

// File: rtl/binary_posit_enc.sv
// binary_posit_enc: sign-magnitude fixed point (1.5.10) to posit8 encoder.
// It uses a multi-cycle normalise/round FSM with valid/ready on both sides.
// Build option: POSIT_ENC_RNE_EN (round-to-nearest-even), otherwise truncate.
module binary_posit_enc #(
  parameter int IN_INT_W  = posit_pkg::K_MAX + 1,
  parameter int IN_FRAC_W = 10,
  parameter int P_FRAC_W  = posit_pkg::P_FRAC_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IN_INT_W+IN_FRAC_W:0]         in_bin,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [posit_pkg::K_W+P_FRAC_W:0]    out_posit,
  output logic                                out_zero,
  output logic                                out_uflow,
  output logic                                out_inexact
);

  import posit_pkg::*;

  localparam int MAG_W = IN_INT_W + IN_FRAC_W;
  localparam int STK_W = MAG_W - 2 - P_FRAC_W;
  localparam logic [K_W-1:0] K_INIT = K_W'(IN_INT_W - 1);

  logic [1:0]              state_q,   state_d;
  logic                    sign_q,    sign_d;
  logic [MAG_W-1:0]        sh_q,      sh_d;
  logic [K_W-1:0]          k_q,       k_d;
  logic [K_W+P_FRAC_W:0]   posit_q,   posit_d;
  logic                    zero_q,    zero_d;
  logic                    uflow_q,   uflow_d;
  logic                    inexact_q, inexact_d;

  logic [MAG_W-1:0]        in_mag;
  logic [IN_INT_W-1:0]     in_int;
  logic [P_FRAC_W-1:0]     rnd_frac;
  logic [K_W-1:0]          rnd_k;
  logic                    rnd_inexact;

  assign in_mag = in_bin[MAG_W-1:0];
  assign in_int = in_bin[MAG_W-1:IN_FRAC_W];

  // Once normalised, the leading one sits in sh_q's MSB.
  // The bits below it are the fraction, then guard, then sticky.
  posit_rne_round #(
    .P_FRAC_W (P_FRAC_W),
    .K_W      (K_W)
  ) u_round (
    .frac_in   (sh_q[MAG_W-2 -: P_FRAC_W]),
    .guard_in  (sh_q[STK_W]),
    .sticky_in (|sh_q[STK_W-1:0]),
    .k_in      (k_q),
    .frac_out  (rnd_frac),
    .k_out     (rnd_k),
    .inexact   (rnd_inexact)
  );

  // Next-state logic: accept, shift toward the MSB, round, then hold until taken.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    sh_d      = sh_q;
    k_d       = k_q;
    posit_d   = posit_q;
    zero_d    = zero_q;
    uflow_d   = uflow_q;
    inexact_d = inexact_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d    = in_bin[MAG_W];
          sh_d      = in_mag;
          k_d       = K_INIT;
          zero_d    = 1'b0;
          uflow_d   = 1'b0;
          inexact_d = 1'b0;
          if (in_mag == '0) begin
            posit_d = {in_bin[MAG_W], {(K_W+P_FRAC_W){1'b0}}};
            zero_d  = 1'b1;
            state_d = ST_DONE;
          end else if (in_int == '0) begin
            posit_d = {in_bin[MAG_W], {(K_W+P_FRAC_W){1'b0}}};
            uflow_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (sh_q[MAG_W-1] || (k_q == '0)) begin
          state_d = ST_ROUND;
        end else begin
          sh_d = {sh_q[MAG_W-2:0], 1'b0};
          k_d  = k_q - K_W'(1);
        end
      end
      ST_ROUND: begin
        posit_d   = {sign_q, rnd_k, rnd_frac};
        inexact_d = rnd_inexact;
        state_d   = ST_DONE;
      end
      default: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and result registers; any reset drops an in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sign_q    <= 1'b0;
      sh_q      <= '0;
      k_q       <= '0;
      posit_q   <= '0;
      zero_q    <= 1'b0;
      uflow_q   <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      sh_q      <= sh_d;
      k_q       <= k_d;
      posit_q   <= posit_d;
      zero_q    <= zero_d;
      uflow_q   <= uflow_d;
      inexact_q <= inexact_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign out_posit   = posit_q;
  assign out_zero    = zero_q;
  assign out_uflow   = uflow_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_binary_posit_enc.sv
// tb_binary_posit_enc: directed vectors with hand-computed posit8 results.
// Expected values for ties and carries follow POSIT_ENC_RNE_EN.
module tb_binary_posit_enc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_posit;
  logic        out_zero;
  logic        out_uflow;
  logic        out_inexact;

  int total_checks  = 0;
  int passed_checks = 0;

`ifdef POSIT_ENC_RNE_EN
  localparam logic [7:0] EXP_TIE   = 8'h02;
  localparam logic [7:0] EXP_CARRY = 8'h10;
  localparam logic [7:0] EXP_MAX   = 8'h50;
`else
  localparam logic [7:0] EXP_TIE   = 8'h01;
  localparam logic [7:0] EXP_CARRY = 8'h0F;
  localparam logic [7:0] EXP_MAX   = 8'h4F;
`endif

  binary_posit_enc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bin      (in_bin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_posit   (out_posit),
    .out_zero    (out_zero),
    .out_uflow   (out_uflow),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one word and count edges until out_valid is seen (bounded).
  task automatic send_word(input logic [15:0] w, output int lat);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    in_valid = 1'b1;
    in_bin   = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 30);
  endtask

  // Take the result and confirm the block is ready again on the next cycle.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_ready_after"}, 16'(in_ready), 16'h1);
    check({tag, "_valid_after"}, 16'(out_valid), 16'h0);
    @(negedge clk);
  endtask

  task automatic run_word(input string tag, input logic [15:0] w, input logic [7:0] exp_posit,
                          input int exp_lat, input logic exp_zero, input logic exp_uflow,
                          input logic exp_inexact, input bit chk_inexact);
    int lat;
    send_word(w, lat);
    check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    check({tag, "_posit"}, 16'(out_posit), 16'(exp_posit));
    check({tag, "_zero"}, 16'(out_zero), 16'(exp_zero));
    check({tag, "_uflow"}, 16'(out_uflow), 16'(exp_uflow));
    if (chk_inexact) check({tag, "_inexact"}, 16'(out_inexact), 16'(exp_inexact));
    check({tag, "_busy"}, 16'(in_ready), 16'h0);
    drain(tag);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bin    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'h1);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_posit", 16'(out_posit), 16'h0);
    check("rst_flags", 16'({out_zero, out_uflow, out_inexact}), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] directed vectors");

    run_word("p3",      16'h0C00, 8'h18,     6, 1'b0, 1'b0, 1'b0, 1'b1);
    run_word("m31",     16'hFC00, 8'hCF,     3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_word("tie",     16'h0460, EXP_TIE,   7, 1'b0, 1'b0, 1'b1, 1'b1);
    run_word("carry",   16'h07E0, EXP_CARRY, 7, 1'b0, 1'b0, 1'b1, 1'b1);
    run_word("max",     16'h7FFF, EXP_MAX,   3, 1'b0, 1'b0, 1'b1, 1'b1);
    run_word("one",     16'h0400, 8'h00,     7, 1'b0, 1'b0, 1'b0, 1'b1);
    run_word("uflow",   16'h0200, 8'h00,     1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_word("negzero", 16'h8000, 8'h80,     1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] backpressure hold");
    send_word(16'h0C00, lat);
    check("hold_lat", 16'(lat), 16'd6);
    in_valid = 1'b1;
    in_bin   = 16'hFC00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_posit", 16'(out_posit), 16'h18);
      check("hold_ready", 16'(in_ready), 16'h0);
      check("hold_valid", 16'(out_valid), 16'h1);
    end
    in_valid = 1'b0;
    drain("hold");
    check("hold_no_extra", 16'(out_valid), 16'h0);

    $display("[TB] reset during normalise");
    in_valid = 1'b1;
    in_bin   = 16'h0400;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", 16'(in_ready), 16'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 16'(in_ready), 16'h1);
    check("midrst_valid", 16'(out_valid), 16'h0);
    check("midrst_posit", 16'(out_posit), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_dropped", 16'(out_valid), 16'h0);
    run_word("post_rst", 16'h0C00, 8'h18, 6, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
